// File: rtl/shift_seq_pkg.sv
// ============================================================================
// shift_seq_pkg : command encodings and FSM states for shift_seq_ctrl
// Revision      : 1.0
// ============================================================================
`default_nettype none

package shift_seq_pkg;

  localparam logic [1:0] OP_LOAD = 2'd0;
  localparam logic [1:0] OP_STEP = 2'd1;
  localparam logic [1:0] OP_RUN  = 2'd2;
  localparam logic [1:0] OP_STOP = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_STEP = 2'd1,
    S_RUN  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/shift_seq_ctrl_tick_gen.sv
// ============================================================================
// tick_gen : free-running prescaler with synchronous clear; one-cycle tick
// Revision : 1.0
// ============================================================================
`default_nettype none

module tick_gen #(
  parameter int TICK_DIV = 25000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && (cnt_q == LAST);

endmodule

`default_nettype wire

// File: rtl/shift_seq_ctrl.sv
// ============================================================================
// shift_seq_ctrl : pattern register + command sequencer feeding a barrel shifter
// Revision       : 1.0
// ============================================================================
`default_nettype none

module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int TICK_DIV = 25000000,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [7:0]       cmd_data,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic [2:0]       cmd_shamt,
  input  logic             cmd_lr,
  input  logic             cmd_al,
  output logic [7:0]       bs_din,
  output logic [2:0]       bs_shamt,
  output logic             bs_lr,
  output logic             bs_al,
  input  logic [7:0]       bs_dout,
  output logic [7:0]       cur_val,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_e           state_q, state_d;
  logic [7:0]       cur_q, cur_d;
  logic [2:0]       shamt_q, shamt_d;
  logic             lr_q, lr_d;
  logic             al_q, al_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic accept;
  logic tick;
  logic presc_clr;
  logic last_tick;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (presc_clr),
    .en    (state_q == S_RUN),
    .tick  (tick)
  );

  assign accept    = cmd_valid && cmd_ready;
  assign last_tick = tick && (rem_q == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      shamt_q <= '0;
      lr_q    <= 1'b0;
      al_q    <= 1'b0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      shamt_q <= shamt_d;
      lr_q    <= lr_d;
      al_q    <= al_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    shamt_d   = shamt_q;
    lr_d      = lr_q;
    al_d      = al_q;
    rem_d     = rem_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    presc_clr = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_LOAD: cur_d = cmd_data;
            OP_STEP: begin
              shamt_d = cmd_shamt;
              lr_d    = cmd_lr;
              al_d    = cmd_al;
              state_d = S_STEP;
            end
            OP_RUN: begin
              shamt_d   = cmd_shamt;
              lr_d      = cmd_lr;
              al_d      = cmd_al;
              rem_d     = cmd_cnt;
              presc_clr = 1'b1;
              state_d   = S_RUN;
            end
            default: ;
          endcase
        end
      end
      S_STEP: begin
        cur_d   = bs_dout;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_RUN: begin
        if (accept && (cmd_op == OP_STOP)) begin
          state_d = S_IDLE;
        end else begin
          // A command landing on the final tick is dropped quietly so done and err never overlap.
          err_d = accept && !last_tick;
          if (tick) begin
            cur_d = bs_dout;
            if (rem_q != '0) begin
              rem_d = rem_q - CNT_W'(1);
            end
            if (last_tick) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q != S_STEP);
    busy      = (state_q != S_IDLE);
    bs_din    = cur_q;
    bs_shamt  = shamt_q;
    bs_lr     = lr_q;
    bs_al     = al_q;
    cur_val   = cur_q;
    done      = done_q;
    err       = err_q;
  end

endmodule

`default_nettype wire
